// File: rtl/tmds_serial_phy.sv
// TMDS serial output stage: serializes three 10-bit TMDS words LSB-first at
// the bit clock rate and generates the matching clock lane, with optional
// per-lane p/n polarity swap for board routing.
module tmds_serial_phy #(
    parameter bit INV_R   = 1'b0,
    parameter bit INV_G   = 1'b0,
    parameter bit INV_B   = 1'b0,
    parameter bit INV_CLK = 1'b0
) (
    input  logic       clk,
    input  logic       rst_pix,
    input  logic       pll_lock,
    input  logic [9:0] tmds_red,
    input  logic [9:0] tmds_green,
    input  logic [9:0] tmds_blue,
    output logic       pix_ce,
    output logic       locked,
    output logic [2:0] tmds_p,
    output logic [2:0] tmds_n,
    output logic       tmds_clk_p,
    output logic       tmds_clk_n
);

    // Clock lane is high for the first five bits of every word.
    localparam logic [9:0] CLK_PATTERN = 10'b0000011111;
    localparam logic [3:0] CNT_LAST    = 4'd9;

    logic       lock_p0;
    logic       lock_p1;
    logic       irst;
    logic [3:0] cnt;
    logic       load_q;
    logic [9:0] sr_red;
    logic [9:0] sr_green;
    logic [9:0] sr_blue;
    logic [9:0] sr_clk;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk) begin
        if (rst_pix) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
        end else begin
            lock_p0 <= pll_lock;
            lock_p1 <= lock_p0;
        end
    end

    assign locked = lock_p1;

    // Losing lock holds the serializer in reset exactly like rst_pix.
    assign irst = rst_pix | ~lock_p1;

    // Mod-10 bit counter; load_q marks the last bit of each word.
    always_ff @(posedge clk) begin
        if (irst) begin
            cnt    <= 4'd0;
            load_q <= 1'b0;
        end else begin
            cnt    <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;
            load_q <= (cnt == CNT_LAST);
        end
    end

    assign pix_ce = load_q;

    // Shift registers: parallel load on load_q, otherwise shift out LSB-first.
    always_ff @(posedge clk) begin
        if (irst) begin
            sr_red   <= 10'd0;
            sr_green <= 10'd0;
            sr_blue  <= 10'd0;
            sr_clk   <= 10'd0;
        end else if (load_q) begin
            sr_red   <= tmds_red;
            sr_green <= tmds_green;
            sr_blue  <= tmds_blue;
            sr_clk   <= CLK_PATTERN;
        end else begin
            sr_red   <= {1'b0, sr_red[9:1]};
            sr_green <= {1'b0, sr_green[9:1]};
            sr_blue  <= {1'b0, sr_blue[9:1]};
            sr_clk   <= {1'b0, sr_clk[9:1]};
        end
    end

    // Pins come straight off the register LSBs so the sampled word's bit 0
    // is visible right after the load edge.
    assign tmds_p     = {sr_red[0] ^ INV_R, sr_green[0] ^ INV_G, sr_blue[0] ^ INV_B};
    assign tmds_n     = ~tmds_p;
    assign tmds_clk_p = sr_clk[0] ^ INV_CLK;
    assign tmds_clk_n = ~tmds_clk_p;

endmodule

// File: tb/tb_tmds_serial_phy.sv
// Directed bench for tmds_serial_phy: default-polarity instance plus an
// instance with green and clock lanes inverted, driven by the same inputs.
module tb_tmds_serial_phy;

    logic       clk;
    logic       rst_pix;
    logic       pll_lock;
    logic [9:0] tmds_red;
    logic [9:0] tmds_green;
    logic [9:0] tmds_blue;

    logic       pix_ce_a, locked_a, clk_p_a, clk_n_a;
    logic [2:0] p_a, n_a;
    logic       pix_ce_b, locked_b, clk_p_b, clk_n_b;
    logic [2:0] p_b, n_b;

    int n_chk;
    int n_pass;

    // Hand-derived LSB-first bit sequences of the test words.
    // red   10'b1101010100, green 10'b0010101011, blue 10'b0101010100
    logic red_seq   [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    logic green_seq [10] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    logic blue_seq  [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic clk_seq   [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    tmds_serial_phy dut_a (
        .clk        (clk),
        .rst_pix    (rst_pix),
        .pll_lock   (pll_lock),
        .tmds_red   (tmds_red),
        .tmds_green (tmds_green),
        .tmds_blue  (tmds_blue),
        .pix_ce     (pix_ce_a),
        .locked     (locked_a),
        .tmds_p     (p_a),
        .tmds_n     (n_a),
        .tmds_clk_p (clk_p_a),
        .tmds_clk_n (clk_n_a)
    );

    tmds_serial_phy #(
        .INV_R   (1'b0),
        .INV_G   (1'b1),
        .INV_B   (1'b0),
        .INV_CLK (1'b1)
    ) dut_b (
        .clk        (clk),
        .rst_pix    (rst_pix),
        .pll_lock   (pll_lock),
        .tmds_red   (tmds_red),
        .tmds_green (tmds_green),
        .tmds_blue  (tmds_blue),
        .pix_ce     (pix_ce_b),
        .locked     (locked_b),
        .tmds_p     (p_b),
        .tmds_n     (n_b),
        .tmds_clk_p (clk_p_b),
        .tmds_clk_n (clk_n_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both instances at reset levels.
    task automatic chk_reset_levels(input string tag);
        chk({tag, "_p_a"},   {29'd0, p_a},             32'b000);
        chk({tag, "_n_a"},   {29'd0, n_a},             32'b111);
        chk({tag, "_clk_a"}, {30'd0, clk_p_a, clk_n_a}, 32'b01);
        chk({tag, "_p_b"},   {29'd0, p_b},             32'b010);
        chk({tag, "_n_b"},   {29'd0, n_b},             32'b101);
        chk({tag, "_clk_b"}, {30'd0, clk_p_b, clk_n_b}, 32'b10);
        chk({tag, "_ce"},    {31'd0, pix_ce_a},        32'd0);
    endtask

    // Edges 1..10 after irst drops: reset levels, pix_ce only after edge 10.
    task automatic chk_startup(input string tag);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk({tag, "_ce"}, {31'd0, pix_ce_a}, (k == 10) ? 32'd1 : 32'd0);
            chk({tag, "_p"},  {28'd0, p_a, clk_p_a}, 32'd0);
        end
    endtask

    logic er, eg, eb, ec;

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst_pix    = 1'b1;
        pll_lock   = 1'b1;
        tmds_red   = 10'b1101010100;
        tmds_green = 10'b0010101011;
        tmds_blue  = 10'b0101010100;

        // Reset for 5 cycles.
        for (int i = 0; i < 5; i++) tick();
        chk_reset_levels("rst");
        chk("rst_locked", {31'd0, locked_a}, 32'd0);

        // Release reset; synchronizer needs two edges to report lock.
        rst_pix = 1'b0;
        tick();
        chk("sync_1", {31'd0, locked_a}, 32'd0);
        tick();
        chk("sync_2", {31'd0, locked_a}, 32'd1);

        chk_startup("start");

        // Edges 11..60: serialization, boundary change and mid-word change.
        for (int k = 0; k < 50; k++) begin
            tick();
            if (k < 30)      er = red_seq[k % 10];
            else if (k < 40) er = 1'b1;
            else             er = 1'b0;
            eg = green_seq[k % 10];
            eb = blue_seq[k % 10];
            ec = clk_seq[k % 10];
            chk("ser_p_a",   {29'd0, p_a}, {29'd0, er, eg, eb});
            chk("ser_n_a",   {29'd0, n_a}, {29'd0, ~er, ~eg, ~eb});
            chk("ser_clk_a", {30'd0, clk_p_a, clk_n_a}, {30'd0, ec, ~ec});
            chk("ser_p_b",   {29'd0, p_b}, {29'd0, er, ~eg, eb});
            chk("ser_clk_b", {30'd0, clk_p_b, clk_n_b}, {30'd0, ~ec, ec});
            chk("ser_ce",    {31'd0, pix_ce_a}, (k % 10 == 9) ? 32'd1 : 32'd0);
            // Mid-word change: must not affect the word in flight.
            if (k == 20) tmds_red = 10'h3FF;
            // Change in the cycle after the sampling edge.
            if (k == 30) tmds_red = 10'h000;
            // Another mid-word change during the all-zero word.
            if (k == 45) tmds_red = 10'h3FF;
        end

        // Edges 61..63: first bits of the 3FF word.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w3ff_red", {31'd0, p_a[2]}, 32'd1);
        end

        // Lock loss mid-word.
        pll_lock = 1'b0;
        tick();
        tick();
        chk("lol_locked", {31'd0, locked_a}, 32'd0);
        tick();
        chk_reset_levels("lol");

        // Relock reproduces the start-up sequence.
        pll_lock = 1'b1;
        tick();
        tick();
        chk("relock", {31'd0, locked_a}, 32'd1);
        chk_startup("relock");
        tick();
        chk("relock_bit0", {30'd0, p_a[2], clk_p_a}, 32'b11);
        tick();
        tick();

        // Reset mid-word: reset levels right after the next edge.
        rst_pix = 1'b1;
        tick();
        chk_reset_levels("rstmid");
        chk("rstmid_locked", {31'd0, locked_a}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tmds_serial_phy.md
Name: tmds_serial_phy

Overview:
- Serial-clock-domain TMDS output stage for the 640x480 HDMI path.
- Takes three 10-bit TMDS words (red, green, blue) from the pixel-domain encoders and serializes them LSB-first at 10x the pixel rate.
- Generates the matching TMDS clock-lane pattern and drives all four lanes as complementary p/n pairs.
- Sits after the PLL/global-buffer clock (250 MHz for a 25 MHz pixel clock) and in front of the LVDS pads.

Parameters:
- INV_R, 0, 1 inverts red-lane polarity (p/n swap) for board routing.
- INV_G, 0, same for green lane.
- INV_B, 0, same for blue lane.
- INV_CLK, 0, same for TMDS clock lane.

Ports:
- clk  in  1  serial bit clock (10x pixel clock, 250 MHz nominal).
- rst_pix  in  1  synchronous active-high reset, sampled on clk.
- pll_lock  in  1  asynchronous PLL lock indication.
- tmds_red  in  10  encoded red word, stable at least 10 clk cycles around each load.
- tmds_green  in  10  encoded green word.
- tmds_blue  in  10  encoded blue word (carries hsync/vsync control codes).
- pix_ce  out  1  one-cycle strobe; words are sampled on the clk edge where pix_ce is 1.
- locked  out  1  synchronized pll_lock.
- tmds_p  out  3  lane positive outputs: [2]=red, [1]=green, [0]=blue.
- tmds_n  out  3  lane negative outputs.
- tmds_clk_p  out  1  clock-lane positive output.
- tmds_clk_n  out  1  clock-lane negative output.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst_pix). There is no asynchronous reset.
- Lock synchronizer: pll_lock passes through a 2-flop synchronizer; the second flop output is locked. Both flops reset to 0.
- Internal reset: irst = rst_pix OR NOT locked, evaluated synchronously.
- Reset state (while irst is 1):
  - mod-10 counter cnt = 0, load_q = 0.
  - Red, green, blue and clock-lane shift registers = 0.
  - pix_ce = 0.
  - Each p output = INV_x; each n output = NOT p.
- Mod-10 counter: cnt counts 0..9, then wraps 9 -> 0; it never holds any value outside 0..9.
- Load strobe: load_q is registered as load_q <= (cnt == 9), so it is 1 for exactly one cycle in every 10.
- pix_ce equals load_q.
- Shift registers, every edge while not in reset:
  - If load_q = 1: each data register takes its input word, and the clock-lane register takes 10'b0000011111.
  - Otherwise: each register shifts right by one, filling 0 at the MSB.
- Serial bit: lane bit = register[0], so words go out LSB first and the TMDS clock lane reads 1,1,1,1,1,0,0,0,0,0 per word.
- Output stage: p = bit XOR INV_x and n = NOT p, both taken directly from register[0] with no extra pipeline stage.
- Timing after irst deasserts, with edge 1 the first edge where irst = 0:
  - cnt reaches 9 after edge 9.
  - load_q = 1 after edge 10.
  - First load happens at edge 11.
  - Bit 0 of the first word appears after edge 11; bit k appears after edge 11+k.
  - Loads then repeat every 10 edges.
  - Latency from the sampling edge to bit 0 on the pins is 0 cycles (visible right after that edge).
- Reset mid-word: the word in flight is discarded immediately; outputs return to reset levels on the next edge.
- Lock loss behaves like reset, after the 2-cycle synchronizer delay.
- Input changes between loads have no effect on the output.
- Word boundary: bit 9 of word N is followed directly by bit 0 of word N+1, with no gap or repeated bit.

Test Plan:
- Reset/lock: pll_lock=1, rst_pix=1 for 5 cycles, then 0 -> outputs stay p=0/n=1 with pix_ce=0 through edge 10; pix_ce=1 after edge 10 only; pix_ce then has period 10.
- Serialization: red=10'b1101010100, green=10'b0010101011, blue=10'b0101010100 held constant -> red p sequence from the first load edge is 0,0,1,0,1,0,1,0,1,1, repeating every 10 bits; green and blue follow the same LSB-first rule; n is always NOT p.
- Clock lane: same run as above -> tmds_clk_p reads 1,1,1,1,1,0,0,0,0,0 aligned to each word's bit 0; the first rising transition coincides with red bit 0.
- Word change at boundary: change red from 10'h3FF to 10'h000 in the cycle after pix_ce -> ten 1s then ten 0s with no glitch; an input change mid-word does not alter the word in flight.
- Lock loss: pll_lock goes 0 mid-word -> within 3 edges locked=0 and outputs are at reset levels; relock reproduces the 10-edge start-up sequence.
- Polarity: INV_G=1, INV_CLK=1 -> green and clock lanes show inverted p and n versus the default run; red and blue are unchanged; reset levels are green p=1 and clock p=1.
